// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller: FSM state encoding,
// operation codes and error codes seen on the front-end/back-end ports.
package atm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LANG   = 4'd1,
        ST_PIN    = 4'd2,
        ST_MENU   = 4'd3,
        ST_DEP    = 4'd4,
        ST_WDR    = 4'd5,
        ST_CHECK  = 4'd6,
        ST_UPDATE = 4'd7,
        ST_SHOW   = 4'd8,
        ST_ERR    = 4'd9,
        ST_EJECT  = 4'd10,
        ST_RETAIN = 4'd11
    } state_t;

    localparam logic [1:0] OP_EJECT = 2'b00;
    localparam logic [1:0] OP_BAL   = 2'b01;
    localparam logic [1:0] OP_DEP   = 2'b10;
    localparam logic [1:0] OP_WDR   = 2'b11;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_PIN  = 3'd1;
    localparam logic [2:0] ERR_INSUFF   = 3'd2;
    localparam logic [2:0] ERR_LIMIT    = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] ERR_ZERO     = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

    // States in which the controller waits on the user and the idle timer runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_LANG) || (s == ST_PIN) || (s == ST_MENU) ||
               (s == ST_DEP)  || (s == ST_WDR);
    endfunction

endpackage

// File: rtl/atm_session_timer.sv
// Inactivity timer: counts enabled cycles since the last clear and pulses
// 'expired' during the cycle in which the count reaches TIMEOUT_CYC-1.
module atm_session_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TIMEOUT_CYC - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_expired;

    // Idle-cycle counter, restarted whenever the controller makes progress
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Flag raised one cycle early so the registered pulse lines up with count LAST
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_expired <= 1'b0;
        end else begin
            r_expired <= enable && (r_cnt == PRE_LAST);
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/atm_ctrl_multi.sv
// ATM session controller: language/PIN/menu flow, deposit and withdraw with
// overflow, balance and per-session limit checks, idle timeout and card
// removal handling. All outputs are registered from the next-state decode.
module atm_ctrl_multi
    import atm_pkg::*;
#(
    parameter int               BAL_W       = 32,
    parameter int               PIN_W       = 16,
    parameter logic [PIN_W-1:0] PIN_VALUE   = 16'h1234,
    parameter logic [BAL_W-1:0] INIT_BAL    = 32'd1000000,
    parameter int               MAX_TRIES   = 3,
    parameter logic [BAL_W-1:0] WD_LIMIT    = 32'd5000,
    parameter int               TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_in,
    input  logic             lang_valid,
    input  logic             lang_sel,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic             amt_valid,
    input  logic [BAL_W-1:0] amount,
    output logic             lang_out,
    output logic [BAL_W-1:0] balance_out,
    output logic             balance_shown,
    output logic             deposit_ok,
    output logic             withdraw_ok,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic             card_eject,
    output logic             card_retained,
    output logic             busy
);

    localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);

    state_t           r_state, w_next;
    logic [BAL_W-1:0] r_balance, r_amount, r_session_wd;
    logic [2:0]       r_tries, w_tries_inc, w_err, r_err_code;
    logic             r_is_dep, r_lang;
    logic             r_balance_shown, r_deposit_ok, r_withdraw_ok, r_err_valid;
    logic             r_card_eject, r_card_retained, r_busy;
    logic             w_accept, w_expired, w_timer_clr, w_timer_en, w_apply;
    logic [BAL_W:0]   w_dep_sum, w_wd_sum;

    // Carry-out and session-limit sums are one bit wider so they never wrap
    assign w_dep_sum   = {1'b0, r_balance} + {1'b0, amount};
    assign w_wd_sum    = {1'b0, r_session_wd} + {1'b0, r_amount};
    assign w_tries_inc = r_tries + 3'd1;
    assign w_apply     = (r_state == ST_UPDATE) && (w_next == ST_SHOW);
    assign w_timer_en  = is_wait_state(r_state);
    assign w_timer_clr = (w_next != r_state) || w_accept;

    atm_session_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clr),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    // Next-state decode: card removal first, then the strobe the state waits on, then timeout
    always_comb begin
        w_next   = r_state;
        w_err    = ERR_NONE;
        w_accept = 1'b0;
        if ((r_state != ST_IDLE) && (r_state != ST_EJECT) &&
            (r_state != ST_RETAIN) && !card_in) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (card_in) w_next = ST_LANG;
                    else         w_next = ST_IDLE;
                end
                ST_LANG: begin
                    if (lang_valid) begin
                        w_accept = 1'b1;
                        w_next   = ST_PIN;
                    end else if (w_expired) begin
                        w_next = ST_ERR;
                        w_err  = ERR_TIMEOUT;
                    end else begin
                        w_next = ST_LANG;
                    end
                end
                ST_PIN: begin
                    if (pin_valid) begin
                        w_accept = 1'b1;
                        if (pin == PIN_VALUE) begin
                            w_next = ST_MENU;
                        end else if (w_tries_inc == TRIES_MAX) begin
                            w_next = ST_RETAIN;
                        end else begin
                            w_next = ST_ERR;
                            w_err  = ERR_BAD_PIN;
                        end
                    end else if (w_expired) begin
                        w_next = ST_ERR;
                        w_err  = ERR_TIMEOUT;
                    end else begin
                        w_next = ST_PIN;
                    end
                end
                ST_MENU: begin
                    if (op_valid) begin
                        w_accept = 1'b1;
                        case (op_code)
                            OP_BAL:  w_next = ST_SHOW;
                            OP_DEP:  w_next = ST_DEP;
                            OP_WDR:  w_next = ST_WDR;
                            default: w_next = ST_EJECT;
                        endcase
                    end else if (w_expired) begin
                        w_next = ST_ERR;
                        w_err  = ERR_TIMEOUT;
                    end else begin
                        w_next = ST_MENU;
                    end
                end
                ST_DEP: begin
                    if (amt_valid) begin
                        w_accept = 1'b1;
                        if (amount == '0) begin
                            w_next = ST_ERR;
                            w_err  = ERR_ZERO;
                        end else if (w_dep_sum[BAL_W]) begin
                            w_next = ST_ERR;
                            w_err  = ERR_OVERFLOW;
                        end else begin
                            w_next = ST_UPDATE;
                        end
                    end else if (w_expired) begin
                        w_next = ST_ERR;
                        w_err  = ERR_TIMEOUT;
                    end else begin
                        w_next = ST_DEP;
                    end
                end
                ST_WDR: begin
                    if (amt_valid) begin
                        w_accept = 1'b1;
                        w_next   = ST_CHECK;
                    end else if (w_expired) begin
                        w_next = ST_ERR;
                        w_err  = ERR_TIMEOUT;
                    end else begin
                        w_next = ST_WDR;
                    end
                end
                ST_CHECK: begin
                    if (r_amount == '0) begin
                        w_next = ST_ERR;
                        w_err  = ERR_ZERO;
                    end else if (r_amount > r_balance) begin
                        w_next = ST_ERR;
                        w_err  = ERR_INSUFF;
                    end else if (w_wd_sum > {1'b0, WD_LIMIT}) begin
                        w_next = ST_ERR;
                        w_err  = ERR_LIMIT;
                    end else begin
                        w_next = ST_UPDATE;
                    end
                end
                ST_UPDATE: w_next = ST_SHOW;
                ST_SHOW:   w_next = ST_MENU;
                ST_ERR: begin
                    case (r_err_code)
                        ERR_BAD_PIN: w_next = ST_PIN;
                        ERR_TIMEOUT: w_next = ST_EJECT;
                        default:     w_next = ST_MENU;
                    endcase
                end
                ST_EJECT:  w_next = ST_IDLE;
                ST_RETAIN: w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // State register plus the language and amount latched on accepted strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_lang   <= 1'b0;
            r_amount <= '0;
            r_is_dep <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_LANG) && w_accept) r_lang <= lang_sel;
            else                                  r_lang <= r_lang;
            if (((r_state == ST_DEP) || (r_state == ST_WDR)) && w_accept) begin
                r_amount <= amount;
                r_is_dep <= (r_state == ST_DEP);
            end else begin
                r_amount <= r_amount;
                r_is_dep <= r_is_dep;
            end
        end
    end

    // Persistent balance and per-session counters; session state drops on any return to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_balance    <= INIT_BAL;
            r_session_wd <= '0;
            r_tries      <= 3'd0;
        end else begin
            if (w_apply && r_is_dep)       r_balance <= r_balance + r_amount;
            else if (w_apply && !r_is_dep) r_balance <= r_balance - r_amount;
            else                           r_balance <= r_balance;

            if (w_next == ST_IDLE)          r_session_wd <= '0;
            else if (w_apply && !r_is_dep)  r_session_wd <= r_session_wd + r_amount;
            else                            r_session_wd <= r_session_wd;

            if (w_next == ST_IDLE)                  r_tries <= 3'd0;
            else if ((r_state == ST_PIN) && w_accept)
                r_tries <= (pin == PIN_VALUE) ? 3'd0 : w_tries_inc;
            else                                    r_tries <= r_tries;
        end
    end

    // Registered Moore outputs decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_balance_shown <= 1'b0;
            r_deposit_ok    <= 1'b0;
            r_withdraw_ok   <= 1'b0;
            r_err_valid     <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_card_eject    <= 1'b0;
            r_card_retained <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_balance_shown <= (w_next == ST_SHOW);
            r_deposit_ok    <= w_apply && r_is_dep;
            r_withdraw_ok   <= w_apply && !r_is_dep;
            r_err_valid     <= (w_next == ST_ERR);
            r_card_eject    <= (w_next == ST_EJECT);
            r_card_retained <= (w_next == ST_RETAIN);
            r_busy          <= (w_next != ST_IDLE);
            if (w_next == ST_ERR)       r_err_code <= w_err;
            else if (w_next == ST_IDLE) r_err_code <= ERR_NONE;
            else                        r_err_code <= r_err_code;
        end
    end

    assign lang_out      = r_lang;
    assign balance_out   = r_balance;
    assign balance_shown = r_balance_shown;
    assign deposit_ok    = r_deposit_ok;
    assign withdraw_ok   = r_withdraw_ok;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;
    assign card_eject    = r_card_eject;
    assign card_retained = r_card_retained;
    assign busy          = r_busy;

endmodule

// File: tb/tb_atm_ctrl_multi.sv
// Directed self-checking bench for atm_ctrl_multi. Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point.
module tb_atm_ctrl_multi;

    logic        clk = 1'b0;
    logic        reset, card_in, lang_valid, lang_sel, pin_valid, op_valid, amt_valid;
    logic [15:0] pin;
    logic [1:0]  op_code;
    logic [31:0] amount;
    logic        lang_out, balance_shown, deposit_ok, withdraw_ok, err_valid;
    logic        card_eject, card_retained, busy;
    logic [31:0] balance_out;
    logic [2:0]  err_code;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_bal;

    atm_ctrl_multi #(
        .BAL_W(32), .PIN_W(16), .PIN_VALUE(16'h1234), .INIT_BAL(32'd1000000),
        .MAX_TRIES(3), .WD_LIMIT(32'd5000), .TIMEOUT_CYC(1024)
    ) dut (
        .clk(clk), .reset(reset), .card_in(card_in), .lang_valid(lang_valid),
        .lang_sel(lang_sel), .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid),
        .op_code(op_code), .amt_valid(amt_valid), .amount(amount),
        .lang_out(lang_out), .balance_out(balance_out), .balance_shown(balance_shown),
        .deposit_ok(deposit_ok), .withdraw_ok(withdraw_ok), .err_valid(err_valid),
        .err_code(err_code), .card_eject(card_eject), .card_retained(card_retained),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_menu(input logic lsel);
        card_in = 1'b1;
        tick();
        lang_valid = 1'b1; lang_sel = lsel;
        tick();
        lang_valid = 1'b0;
        pin_valid = 1'b1; pin = 16'h1234;
        tick();
        pin_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] code);
        op_valid = 1'b1; op_code = code;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_amt(input logic [31:0] a);
        amt_valid = 1'b1; amount = a;
        tick();
        amt_valid = 1'b0;
    endtask

    task automatic eject_card();
        do_op(2'b00);
        card_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; card_in = 1'b0; lang_valid = 1'b0; lang_sel = 1'b0;
        pin_valid = 1'b0; pin = 16'h0000; op_valid = 1'b0; op_code = 2'b00;
        amt_valid = 1'b0; amount = 32'd0;
        tick(2);
        n_tests++; if (balance_out !== 32'd1000000) begin n_fail++; $display("FAIL reset_balance: got %0d want 1000000", balance_out); end
        n_tests++; if ({busy, balance_shown, deposit_ok, withdraw_ok, err_valid, card_eject, card_retained, lang_out} !== 8'd0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 00000000", {busy, balance_shown, deposit_ok, withdraw_ok, err_valid, card_eject, card_retained, lang_out}); end
        n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        reset = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_card_busy: got %b want 0", busy); end
    endtask

    task automatic test_balance_eject();
        go_menu(1'b1);
        n_tests++; if ({busy, lang_out} !== 2'b11) begin n_fail++; $display("FAIL menu_busy_lang: got %b want 11", {busy, lang_out}); end
        do_op(2'b01);
        n_tests++; if ({balance_shown, deposit_ok, withdraw_ok} !== 3'b100) begin n_fail++; $display("FAIL show_pulse: got %b want 100", {balance_shown, deposit_ok, withdraw_ok}); end
        n_tests++; if (balance_out !== 32'd1000000) begin n_fail++; $display("FAIL show_balance: got %0d want 1000000", balance_out); end
        tick();
        n_tests++; if (balance_shown !== 1'b0) begin n_fail++; $display("FAIL show_one_cycle: got %b want 0", balance_shown); end
        do_op(2'b00);
        n_tests++; if ({card_eject, busy} !== 2'b11) begin n_fail++; $display("FAIL eject_pulse: got %b want 11", {card_eject, busy}); end
        card_in = 1'b0;
        tick();
        n_tests++; if ({card_eject, busy} !== 2'b00) begin n_fail++; $display("FAIL eject_idle: got %b want 00", {card_eject, busy}); end
    endtask

    task automatic test_deposit_withdraw();
        go_menu(1'b0);
        n_tests++; if (lang_out !== 1'b0) begin n_fail++; $display("FAIL lang_relatch: got %b want 0", lang_out); end
        do_op(2'b10);
        do_amt(32'd250);
        n_tests++; if (deposit_ok !== 1'b0) begin n_fail++; $display("FAIL dep_early: got %b want 0", deposit_ok); end
        tick();
        n_tests++; if ({deposit_ok, balance_shown} !== 2'b11) begin n_fail++; $display("FAIL dep_ok_k2: got %b want 11", {deposit_ok, balance_shown}); end
        n_tests++; if (balance_out !== 32'd1000250) begin n_fail++; $display("FAIL dep_balance: got %0d want 1000250", balance_out); end
        tick();
        do_op(2'b11);
        do_amt(32'd1000);
        tick();
        n_tests++; if (withdraw_ok !== 1'b0 || balance_out !== 32'd1000250) begin n_fail++; $display("FAIL wdr_k2: got ok=%b bal=%0d want ok=0 bal=1000250", withdraw_ok, balance_out); end
        tick();
        n_tests++; if ({withdraw_ok, deposit_ok} !== 2'b10) begin n_fail++; $display("FAIL wdr_ok_k3: got %b want 10", {withdraw_ok, deposit_ok}); end
        n_tests++; if (balance_out !== 32'd999250) begin n_fail++; $display("FAIL wdr_balance: got %0d want 999250", balance_out); end
        tick();
        eject_card();
    endtask

    task automatic test_bad_pin();
        card_in = 1'b1;
        tick();
        lang_valid = 1'b1; tick(); lang_valid = 1'b0;
        for (int t = 0; t < 2; t++) begin
            pin_valid = 1'b1; pin = 16'h0000; tick(); pin_valid = 1'b0;
            n_tests++; if ({err_valid, err_code} !== 4'b1001) begin n_fail++; $display("FAIL bad_pin_err%0d: got v=%b c=%0d want v=1 c=1", t, err_valid, err_code); end
            tick();
            n_tests++; if ({err_valid, err_code} !== 4'b0001) begin n_fail++; $display("FAIL bad_pin_hold%0d: got v=%b c=%0d want v=0 c=1", t, err_valid, err_code); end
        end
        pin_valid = 1'b1; pin = 16'h4321; tick(); pin_valid = 1'b0;
        n_tests++; if ({card_retained, err_valid} !== 2'b10) begin n_fail++; $display("FAIL retain_pulse: got %b want 10", {card_retained, err_valid}); end
        card_in = 1'b0;
        tick();
        n_tests++; if ({card_retained, busy, err_code} !== 5'b00000) begin n_fail++; $display("FAIL retain_idle: got %b want 00000", {card_retained, busy, err_code}); end
        card_in = 1'b1;
        tick();
        lang_valid = 1'b1; tick(); lang_valid = 1'b0;
        pin_valid = 1'b1; pin = 16'h1235; tick(); pin_valid = 1'b0;
        n_tests++; if ({card_retained, err_valid, err_code} !== 5'b01001) begin n_fail++; $display("FAIL tries_cleared: got %b want 01001", {card_retained, err_valid, err_code}); end
        tick();
        pin_valid = 1'b1; pin = 16'h1234; tick(); pin_valid = 1'b0;
        do_op(2'b01);
        n_tests++; if (balance_shown !== 1'b1) begin n_fail++; $display("FAIL pin_ok_menu: got %b want 1", balance_shown); end
        tick();
        eject_card();
    endtask

    task automatic test_limits();
        go_menu(1'b0);
        do_op(2'b11); do_amt(32'd4000); tick(2);
        n_tests++; if (withdraw_ok !== 1'b1 || balance_out !== 32'd995250) begin n_fail++; $display("FAIL wdr4000: got ok=%b bal=%0d want ok=1 bal=995250", withdraw_ok, balance_out); end
        tick();
        do_op(2'b11); do_amt(32'd2000); tick();
        n_tests++; if ({err_valid, err_code} !== 4'b1011 || balance_out !== 32'd995250) begin n_fail++; $display("FAIL wd_limit: got v=%b c=%0d bal=%0d want v=1 c=3 bal=995250", err_valid, err_code, balance_out); end
        tick();
        do_op(2'b11); do_amt(32'd1000); tick(2);
        n_tests++; if (withdraw_ok !== 1'b1 || balance_out !== 32'd994250) begin n_fail++; $display("FAIL wd_at_limit: got ok=%b bal=%0d want ok=1 bal=994250", withdraw_ok, balance_out); end
        tick();
        do_op(2'b10); do_amt(32'd4293973036); tick();
        exp_bal = 32'hFFFF_FFF6;
        n_tests++; if (deposit_ok !== 1'b1 || balance_out !== exp_bal) begin n_fail++; $display("FAIL dep_big: got ok=%b bal=%h want ok=1 bal=%h", deposit_ok, balance_out, exp_bal); end
        tick();
        do_op(2'b10); do_amt(32'd10);
        n_tests++; if ({err_valid, err_code} !== 4'b1100 || balance_out !== exp_bal) begin n_fail++; $display("FAIL dep_overflow: got v=%b c=%0d bal=%h want v=1 c=4 bal=%h", err_valid, err_code, balance_out, exp_bal); end
        tick();
        do_op(2'b11); do_amt(32'd0); tick();
        n_tests++; if ({err_valid, err_code} !== 4'b1101) begin n_fail++; $display("FAIL wd_zero: got v=%b c=%0d want v=1 c=5", err_valid, err_code); end
        tick();
        do_op(2'b11); do_amt(32'hFFFF_FFFF); tick();
        n_tests++; if ({err_valid, err_code} !== 4'b1010 || balance_out !== exp_bal) begin n_fail++; $display("FAIL wd_insuff: got v=%b c=%0d bal=%h want v=1 c=2 bal=%h", err_valid, err_code, balance_out, exp_bal); end
        tick();
        eject_card();
    endtask

    task automatic test_timeout();
        go_menu(1'b0);
        tick(1023);
        n_tests++; if ({busy, err_valid} !== 2'b10) begin n_fail++; $display("FAIL timeout_early: got %b want 10", {busy, err_valid}); end
        tick();
        n_tests++; if ({err_valid, err_code} !== 4'b1110) begin n_fail++; $display("FAIL timeout_err: got v=%b c=%0d want v=1 c=6", err_valid, err_code); end
        tick();
        n_tests++; if (card_eject !== 1'b1) begin n_fail++; $display("FAIL timeout_eject: got %b want 1", card_eject); end
        card_in = 1'b0;
        tick();
        n_tests++; if ({busy, err_code} !== 4'b0000) begin n_fail++; $display("FAIL timeout_idle: got %b want 0000", {busy, err_code}); end
    endtask

    task automatic test_card_pull();
        go_menu(1'b0);
        do_op(2'b11);
        do_amt(32'd100);
        card_in = 1'b0;
        tick();
        n_tests++; if ({busy, withdraw_ok, card_eject} !== 3'b000) begin n_fail++; $display("FAIL pull_idle: got %b want 000", {busy, withdraw_ok, card_eject}); end
        tick(3);
        n_tests++; if (balance_out !== exp_bal) begin n_fail++; $display("FAIL pull_balance: got %h want %h", balance_out, exp_bal); end
    endtask

    task automatic test_reset_update();
        go_menu(1'b1);
        do_op(2'b10);
        do_amt(32'd5);
        reset = 1'b1; card_in = 1'b0;
        tick();
        n_tests++; if ({busy, deposit_ok, balance_shown, lang_out, err_valid} !== 5'b00000) begin n_fail++; $display("FAIL rst_update_flags: got %b want 00000", {busy, deposit_ok, balance_shown, lang_out, err_valid}); end
        n_tests++; if (balance_out !== 32'd1000000) begin n_fail++; $display("FAIL rst_update_balance: got %0d want 1000000", balance_out); end
        reset = 1'b0;
        tick(2);
        n_tests++; if (balance_out !== 32'd1000000 || deposit_ok !== 1'b0) begin n_fail++; $display("FAIL rst_update_after: got bal=%0d ok=%b want bal=1000000 ok=0", balance_out, deposit_ok); end
    endtask

    initial begin
        exp_bal = 32'd0;
        test_reset();
        test_balance_eject();
        test_deposit_withdraw();
        test_bad_pin();
        test_limits();
        test_timeout();
        test_card_pull();
        test_reset_update();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
